// File: rtl/tmr_irq_pkg.sv
// Shared definitions for the timer interrupt arbiter: FSM states,
// source index constants and default sizing.
package tmr_irq_pkg;

    localparam int TMR_NUM_SRC   = 6;
    localparam int TMR_VEC_WIDTH = 3;

    // Source indices; index 0 is the highest priority
    localparam int SRC_CMIA0 = 0;
    localparam int SRC_CMIB0 = 1;
    localparam int SRC_OVI0  = 2;
    localparam int SRC_CMIA1 = 3;
    localparam int SRC_CMIB1 = 4;
    localparam int SRC_OVI1  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } tmr_irq_state_e;

endpackage

// File: rtl/tmr_irq_arbiter_if.sv
// CPU interrupt handshake: request and vector from the arbiter,
// acknowledge from the CPU.
interface tmr_irq_arbiter_if
    import tmr_irq_pkg::*;
#(
    parameter int VEC_WIDTH = TMR_VEC_WIDTH
);
    logic                 irq_req;
    logic [VEC_WIDTH-1:0] irq_vec;
    logic                 irq_ack;

    modport master (output irq_req, output irq_vec, input  irq_ack);
    modport slave  (input  irq_req, input  irq_vec, output irq_ack);
endinterface

// File: rtl/tmr_irq_prio_enc.sv
// Lowest-index-first priority encoder: reports whether any mask bit is set
// and the index of the lowest set bit, zero-extended to VEC_WIDTH.
module tmr_irq_prio_enc #(
    parameter int NUM_SRC   = 6,
    parameter int VEC_WIDTH = 3
) (
    input  logic [NUM_SRC-1:0]   mask_i,
    output logic                 valid_o,
    output logic [VEC_WIDTH-1:0] idx_o
);
    logic [VEC_WIDTH-1:0] idx_s;

    // Scan from the top down so the lowest set index is the one that remains
    always_comb begin
        idx_s = {VEC_WIDTH{1'b0}};
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            idx_s = mask_i[i] ? VEC_WIDTH'(i) : idx_s;
        end
    end

    assign valid_o = |mask_i;
    assign idx_o   = idx_s;
endmodule

// File: rtl/tmr_irq_arbiter.sv
// Timer interrupt arbiter: edge-detects the six timer flags into pending
// bits, grants the highest-priority enabled one to the CPU over a req/ack
// handshake, and forces a one-cycle request gap between grants.
// Optional feature macro: TMR_IRQ_OVERRUN_EN builds sticky overrun flags;
// without it overrun_o is constant zero.
module tmr_irq_arbiter
    import tmr_irq_pkg::*;
#(
    parameter int NUM_SRC   = TMR_NUM_SRC,
    parameter int VEC_WIDTH = TMR_VEC_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_SRC-1:0]  src_evt_i,
    input  logic [NUM_SRC-1:0]  src_en_i,
    input  logic [NUM_SRC-1:0]  pend_clr_i,
    tmr_irq_arbiter_if.master   irq_bus,
    output logic [NUM_SRC-1:0]  pending_o,
    output logic [NUM_SRC-1:0]  overrun_o
);
    tmr_irq_state_e       state_q, state_d;
    logic                 irq_req_q, irq_req_d;
    logic [VEC_WIDTH-1:0] irq_vec_q, irq_vec_d;
    logic [NUM_SRC-1:0]   evt_hist_q;
    logic [NUM_SRC-1:0]   pending_q, pending_d;
    logic [NUM_SRC-1:0]   edge_s, sel_s, clr_s;
    logic                 ack_s, withdraw_s;
    logic                 enc_valid_s;
    logic [VEC_WIDTH-1:0] enc_idx_s;

    tmr_irq_prio_enc #(
        .NUM_SRC   (NUM_SRC),
        .VEC_WIDTH (VEC_WIDTH)
    ) u_prio_enc (
        .mask_i  (pending_q & src_en_i),
        .valid_o (enc_valid_s),
        .idx_o   (enc_idx_s)
    );

    assign edge_s = src_evt_i & ~evt_hist_q;
    assign ack_s  = irq_bus.irq_ack && (state_q == REQ);

    // One-hot of the granted source, and the combined clear (software + ack)
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            sel_s[i] = (irq_vec_q == VEC_WIDTH'(i));
        end
        clr_s      = pend_clr_i | (ack_s ? sel_s : {NUM_SRC{1'b0}});
        pending_d  = edge_s | (pending_q & ~clr_s);
        withdraw_s = |(sel_s & pend_clr_i & ~edge_s);
    end

    // Edge history and pending bits; a new edge always wins over a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_hist_q <= {NUM_SRC{1'b0}};
            pending_q  <= {NUM_SRC{1'b0}};
        end else begin
            evt_hist_q <= src_evt_i;
            pending_q  <= pending_d;
        end
    end

`ifdef TMR_IRQ_OVERRUN_EN
    logic [NUM_SRC-1:0] overrun_q;

    // Sticky lost-event flags: edge on an already pending, uncleared source
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= {NUM_SRC{1'b0}};
        end else begin
            overrun_q <= (overrun_q & ~pend_clr_i) | (edge_s & pending_q & ~clr_s);
        end
    end

    assign overrun_o = overrun_q;
`else
    assign overrun_o = {NUM_SRC{1'b0}};
`endif

    // Grant FSM: latch the winner in IDLE, hold it through REQ, gap after ack
    always_comb begin
        state_d   = state_q;
        irq_req_d = irq_req_q;
        irq_vec_d = irq_vec_q;
        case (state_q)
            IDLE: begin
                if (enc_valid_s) begin
                    irq_vec_d = enc_idx_s;
                    irq_req_d = 1'b1;
                    state_d   = REQ;
                end else begin
                    irq_req_d = 1'b0;
                end
            end
            REQ: begin
                if (ack_s) begin
                    irq_req_d = 1'b0;
                    state_d   = GAP;
                end else if (withdraw_s) begin
                    irq_req_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    irq_req_d = 1'b1;
                end
            end
            GAP: begin
                irq_req_d = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                irq_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // FSM state and registered request/vector outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            irq_req_q <= 1'b0;
            irq_vec_q <= {VEC_WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            irq_req_q <= irq_req_d;
            irq_vec_q <= irq_vec_d;
        end
    end

    assign irq_bus.irq_req = irq_req_q;
    assign irq_bus.irq_vec = irq_vec_q;
    assign pending_o       = pending_q;
endmodule

// File: tb/tb_tmr_irq_arbiter.sv
// Directed, table-driven bench for tmr_irq_arbiter. Each table row is one
// clock: inputs are driven on the falling edge and outputs are compared
// 1 time unit after the following rising edge.
module tb_tmr_irq_arbiter;
    import tmr_irq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] src_evt, src_en, pend_clr;
    logic [5:0] pending, overrun;

    int total_cnt = 0;
    int pass_cnt  = 0;

`ifdef TMR_IRQ_OVERRUN_EN
    localparam logic [5:0] OVR_MASK = 6'h3F;
`else
    localparam logic [5:0] OVR_MASK = 6'h00;
`endif

    always #5 clk = ~clk;

    tmr_irq_arbiter_if #(.VEC_WIDTH(3)) irq_if ();

    tmr_irq_arbiter #(.NUM_SRC(6), .VEC_WIDTH(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_evt_i  (src_evt),
        .src_en_i   (src_en),
        .pend_clr_i (pend_clr),
        .irq_bus    (irq_if),
        .pending_o  (pending),
        .overrun_o  (overrun)
    );

    typedef struct {
        logic [5:0] evt;
        logic [5:0] en;
        logic [5:0] clr;
        logic       ack;
        logic       req;
        logic [2:0] vec;
        logic [5:0] pend;
        logic [5:0] ovr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [5:0] evt, input logic [5:0] en, input logic [5:0] clr,
                       input logic ack, input logic req, input logic [2:0] vec,
                       input logic [5:0] pend, input logic [5:0] ovr);
        vec_t r;
        r.evt = evt; r.en = en; r.clr = clr; r.ack = ack;
        r.req = req; r.vec = vec; r.pend = pend; r.ovr = ovr & OVR_MASK;
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input int step, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
        end
    endtask

    task automatic chk_all(input int step, input logic req, input logic [2:0] vec,
                           input logic [5:0] pend, input logic [5:0] ovr);
        chk("irq_req", step, {7'd0, irq_if.irq_req}, {7'd0, req});
        chk("irq_vec", step, {5'd0, irq_if.irq_vec}, {5'd0, vec});
        chk("pending", step, {2'd0, pending}, {2'd0, pend});
        chk("overrun", step, {2'd0, overrun}, {2'd0, ovr});
    endtask

    initial begin
        // 1: single event, 2-cycle latency, ack then gap
        add(6'h01, 6'h3F, 6'h00, 1'b0, 1'b0, 3'd0, 6'h01, 6'h00);
        add(6'h01, 6'h3F, 6'h00, 1'b0, 1'b1, 3'd0, 6'h01, 6'h00);
        add(6'h00, 6'h3F, 6'h00, 1'b1, 1'b0, 3'd0, 6'h00, 6'h00);
        add(6'h00, 6'h3F, 6'h00, 1'b0, 1'b0, 3'd0, 6'h00, 6'h00);
        // 2: priority between bits 1 and 4
        add(6'h12, 6'h3F, 6'h00, 1'b0, 1'b0, 3'd0, 6'h12, 6'h00);
        add(6'h12, 6'h3F, 6'h00, 1'b0, 1'b1, 3'd1, 6'h12, 6'h00);
        add(6'h12, 6'h3F, 6'h00, 1'b1, 1'b0, 3'd1, 6'h10, 6'h00);
        add(6'h12, 6'h3F, 6'h00, 1'b0, 1'b0, 3'd1, 6'h10, 6'h00);
        add(6'h00, 6'h3F, 6'h00, 1'b0, 1'b1, 3'd4, 6'h10, 6'h00);
        add(6'h00, 6'h3F, 6'h00, 1'b1, 1'b0, 3'd4, 6'h00, 6'h00);
        add(6'h00, 6'h3F, 6'h00, 1'b0, 1'b0, 3'd4, 6'h00, 6'h00);
        // 3: no preemption of vec 3 by bit 0
        add(6'h08, 6'h3F, 6'h00, 1'b0, 1'b0, 3'd4, 6'h08, 6'h00);
        add(6'h08, 6'h3F, 6'h00, 1'b0, 1'b1, 3'd3, 6'h08, 6'h00);
        add(6'h09, 6'h3F, 6'h00, 1'b0, 1'b1, 3'd3, 6'h09, 6'h00);
        add(6'h09, 6'h3F, 6'h00, 1'b0, 1'b1, 3'd3, 6'h09, 6'h00);
        add(6'h00, 6'h3F, 6'h00, 1'b1, 1'b0, 3'd3, 6'h01, 6'h00);
        add(6'h00, 6'h3F, 6'h00, 1'b0, 1'b0, 3'd3, 6'h01, 6'h00);
        add(6'h00, 6'h3F, 6'h00, 1'b0, 1'b1, 3'd0, 6'h01, 6'h00);
        add(6'h00, 6'h3F, 6'h00, 1'b1, 1'b0, 3'd0, 6'h00, 6'h00);
        add(6'h00, 6'h3F, 6'h00, 1'b0, 1'b0, 3'd0, 6'h00, 6'h00);
        // 4: masked event stays pending; pend_clr withdraws, no gap
        add(6'h04, 6'h00, 6'h00, 1'b0, 1'b0, 3'd0, 6'h04, 6'h00);
        add(6'h00, 6'h00, 6'h00, 1'b0, 1'b0, 3'd0, 6'h04, 6'h00);
        add(6'h00, 6'h00, 6'h00, 1'b0, 1'b0, 3'd0, 6'h04, 6'h00);
        add(6'h00, 6'h3F, 6'h00, 1'b0, 1'b1, 3'd2, 6'h04, 6'h00);
        add(6'h02, 6'h3F, 6'h04, 1'b0, 1'b0, 3'd2, 6'h02, 6'h00);
        add(6'h00, 6'h3F, 6'h00, 1'b0, 1'b1, 3'd1, 6'h02, 6'h00);
        add(6'h00, 6'h3F, 6'h00, 1'b1, 1'b0, 3'd1, 6'h00, 6'h00);
        add(6'h00, 6'h3F, 6'h00, 1'b0, 1'b0, 3'd1, 6'h00, 6'h00);
        // ack outside REQ is ignored
        add(6'h20, 6'h00, 6'h00, 1'b0, 1'b0, 3'd1, 6'h20, 6'h00);
        add(6'h20, 6'h00, 6'h00, 1'b1, 1'b0, 3'd1, 6'h20, 6'h00);
        // 5: set-wins on ack of vec 5, re-request, overrun and its clear
        add(6'h00, 6'h3F, 6'h00, 1'b0, 1'b1, 3'd5, 6'h20, 6'h00);
        add(6'h20, 6'h3F, 6'h00, 1'b1, 1'b0, 3'd5, 6'h20, 6'h00);
        add(6'h20, 6'h3F, 6'h00, 1'b0, 1'b0, 3'd5, 6'h20, 6'h00);
        add(6'h00, 6'h3F, 6'h00, 1'b0, 1'b1, 3'd5, 6'h20, 6'h00);
        add(6'h20, 6'h3F, 6'h00, 1'b0, 1'b1, 3'd5, 6'h20, 6'h20);
        add(6'h00, 6'h3F, 6'h20, 1'b0, 1'b0, 3'd5, 6'h00, 6'h00);
        add(6'h00, 6'h3F, 6'h00, 1'b0, 1'b0, 3'd5, 6'h00, 6'h00);
        // ack and pend_clr together act as ack (gap follows)
        add(6'h01, 6'h3F, 6'h00, 1'b0, 1'b0, 3'd5, 6'h01, 6'h00);
        add(6'h00, 6'h3F, 6'h00, 1'b0, 1'b1, 3'd0, 6'h01, 6'h00);
        add(6'h02, 6'h3F, 6'h01, 1'b1, 1'b0, 3'd0, 6'h02, 6'h00);
        add(6'h02, 6'h3F, 6'h00, 1'b0, 1'b0, 3'd0, 6'h02, 6'h00);
        add(6'h00, 6'h3F, 6'h00, 1'b0, 1'b1, 3'd1, 6'h02, 6'h00);
        add(6'h00, 6'h3F, 6'h00, 1'b1, 1'b0, 3'd1, 6'h00, 6'h00);
        add(6'h00, 6'h3F, 6'h00, 1'b0, 1'b0, 3'd1, 6'h00, 6'h00);

        // Reset state
        rst_n = 1'b0; src_evt = 6'h00; src_en = 6'h3F; pend_clr = 6'h00; irq_if.irq_ack = 1'b0;
        #12;
        chk_all(-1, 1'b0, 3'd0, 6'h00, 6'h00);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[k]) begin
            @(negedge clk);
            src_evt = tbl[k].evt; src_en = tbl[k].en;
            pend_clr = tbl[k].clr; irq_if.irq_ack = tbl[k].ack;
            @(posedge clk); #1;
            chk_all(k, tbl[k].req, tbl[k].vec, tbl[k].pend, tbl[k].ovr);
        end

        // 6: asynchronous reset in the middle of a request on vec 3
        @(negedge clk); src_evt = 6'h08; pend_clr = 6'h00; irq_if.irq_ack = 1'b0;
        @(negedge clk); src_evt = 6'h00;
        @(posedge clk); #1;
        chk_all(100, 1'b1, 3'd3, 6'h08, 6'h00);
        #2; rst_n = 1'b0; #1;
        chk_all(101, 1'b0, 3'd0, 6'h00, 6'h00);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk_all(102, 1'b0, 3'd0, 6'h00, 6'h00);
        @(posedge clk); #1;
        chk_all(103, 1'b0, 3'd0, 6'h00, 6'h00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
